// File: rtl/electro_step_sequencer.sv
// Step sequencer for the long-range electrostatics engine: LOAD -> SPREAD -> SOLVE -> READ -> DONE.
// Optional SPREAD/SOLVE watchdog is enabled by defining ELECTRO_WATCHDOG_EN.
module electro_step_sequencer #(
    parameter int unsigned NUM_PARTICLES  = 2048,
    parameter int unsigned ADDR_W         = 11,
    parameter int unsigned DATA_W         = 128,
    parameter int unsigned WORD_CYCLES    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        start_sig,
    input  logic [DATA_W-1:0] user_buffer_data,
    input  logic              user_data_available,
    input  logic              spread_done,
    input  logic              solve_done,
    output logic              particle_wr_en,
    output logic [ADDR_W-1:0] particle_addr,
    output logic [DATA_W-1:0] particle_wr_data,
    output logic              spread_start,
    output logic              solve_start,
    output logic              force_rd_en,
    output logic [ADDR_W-1:0] force_addr,
    output logic              busy,
    output logic              step_done,
    output logic              err
);

    localparam int unsigned       PACE_W      = $clog2(WORD_CYCLES);
    localparam logic [PACE_W-1:0] LP_PACE_MAX = PACE_W'(WORD_CYCLES - 1);
    localparam logic [ADDR_W:0]   LP_NUM      = (ADDR_W + 1)'(NUM_PARTICLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SPREAD,
        S_SOLVE,
        S_READ,
        S_DONE,
        S_ERR
    } state_t;

    state_t            r_state;
    logic [PACE_W-1:0] r_pace;
    logic [ADDR_W:0]   r_widx;   // one bit wider so "all words done" is distinct from any address
    logic              r_first;  // first cycle of SPREAD/SOLVE: done pulse not yet honoured

`ifdef ELECTRO_WATCHDOG_EN
    localparam int unsigned       WDOG_W = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WDOG_W-1:0] LP_TMO = WDOG_W'(TIMEOUT_CYCLES - 1);
    logic [WDOG_W-1:0] r_wdog;
`else
    assign err = 1'b0;
`endif

    logic w_stream;
    logic w_sample;
    logic w_last;

    assign w_stream = (r_state == S_LOAD) || (r_state == S_READ);
    assign w_sample = w_stream && user_data_available && (r_pace == '0);
    assign w_last   = (r_widx == LP_NUM);
    assign busy     = (r_state != S_IDLE) && (r_state != S_ERR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state          <= S_IDLE;
            r_pace           <= '0;
            r_widx           <= '0;
            r_first          <= 1'b0;
            particle_wr_en   <= 1'b0;
            particle_addr    <= '0;
            particle_wr_data <= '0;
            spread_start     <= 1'b0;
            solve_start      <= 1'b0;
            force_rd_en      <= 1'b0;
            force_addr       <= '0;
            step_done        <= 1'b0;
`ifdef ELECTRO_WATCHDOG_EN
            r_wdog           <= '0;
            err              <= 1'b0;
`endif
        end else begin
            particle_wr_en <= 1'b0;
            spread_start   <= 1'b0;
            solve_start    <= 1'b0;
            force_rd_en    <= 1'b0;
            step_done      <= 1'b0;

            // Pace counter only runs while the host stream is active; a pause restarts it at 0.
            if (w_stream && user_data_available) begin
                r_pace <= (r_pace == LP_PACE_MAX) ? '0 : r_pace + 1'b1;
            end else begin
                r_pace <= '0;
            end

            case (r_state)
                S_IDLE, S_ERR: begin
                    if (start_sig != 2'b00) begin
                        r_state       <= start_sig[0] ? S_LOAD : S_READ;
                        particle_addr <= '0;
                        force_addr    <= '0;
                        r_widx        <= '0;
`ifdef ELECTRO_WATCHDOG_EN
                        err           <= 1'b0;
`endif
                    end
                end
                S_LOAD: begin
                    if (w_last) begin
                        r_state      <= S_SPREAD;
                        spread_start <= 1'b1;
                        r_first      <= 1'b1;
                        r_widx       <= '0;
`ifdef ELECTRO_WATCHDOG_EN
                        r_wdog       <= '0;
`endif
                    end else if (w_sample) begin
                        particle_wr_en   <= 1'b1;
                        particle_addr    <= r_widx[ADDR_W-1:0];
                        particle_wr_data <= user_buffer_data;
                        r_widx           <= r_widx + 1'b1;
                    end
                end
                S_SPREAD: begin
                    r_first <= 1'b0;
                    if (!r_first && spread_done) begin
                        r_state     <= S_SOLVE;
                        solve_start <= 1'b1;
                        r_first     <= 1'b1;
`ifdef ELECTRO_WATCHDOG_EN
                        r_wdog      <= '0;
                    end else if (r_wdog == LP_TMO) begin
                        r_state <= S_ERR;
                        err     <= 1'b1;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
`endif
                    end
                end
                S_SOLVE: begin
                    r_first <= 1'b0;
                    if (!r_first && solve_done) begin
                        r_state <= S_READ;
`ifdef ELECTRO_WATCHDOG_EN
                    end else if (r_wdog == LP_TMO) begin
                        r_state <= S_ERR;
                        err     <= 1'b1;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
`endif
                    end
                end
                S_READ: begin
                    if (w_last) begin
                        r_state   <= S_DONE;
                        step_done <= 1'b1;
                    end else if (w_sample) begin
                        force_rd_en <= 1'b1;
                        force_addr  <= r_widx[ADDR_W-1:0];
                        r_widx      <= r_widx + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_electro_step_sequencer.sv
// Self-checking bench for electro_step_sequencer: start-decode vector table plus scoreboarded full,
// paused, readback-only, reset-abort and watchdog scenarios (watchdog expectations follow ELECTRO_WATCHDOG_EN).
`timescale 1ns/1ps
module tb_electro_step_sequencer;

    localparam int NP  = 2048;
    localparam int AW  = 11;
    localparam int DW  = 128;
    localparam int WC  = 4;
    localparam int TMO = 1000;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    start_sig;
    logic [DW-1:0] user_buffer_data;
    logic          user_data_available;
    logic          spread_done;
    logic          solve_done;
    logic          particle_wr_en;
    logic [AW-1:0] particle_addr;
    logic [DW-1:0] particle_wr_data;
    logic          spread_start;
    logic          solve_start;
    logic          force_rd_en;
    logic [AW-1:0] force_addr;
    logic          busy;
    logic          step_done;
    logic          err;

    always #5 clk = ~clk;

    electro_step_sequencer #(
        .NUM_PARTICLES (NP),
        .ADDR_W        (AW),
        .DATA_W        (DW),
        .WORD_CYCLES   (WC),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .start_sig          (start_sig),
        .user_buffer_data   (user_buffer_data),
        .user_data_available(user_data_available),
        .spread_done        (spread_done),
        .solve_done         (solve_done),
        .particle_wr_en     (particle_wr_en),
        .particle_addr      (particle_addr),
        .particle_wr_data   (particle_wr_data),
        .spread_start       (spread_start),
        .solve_start        (solve_start),
        .force_rd_en        (force_rd_en),
        .force_addr         (force_addr),
        .busy               (busy),
        .step_done          (step_done),
        .err                (err)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic [1:0] start;
        logic       exp_busy;
        int         exp_wr;
        int         exp_rd;
    } vec_t;

    int            checks   = 0;
    int            failures = 0;
    wr_t           exp_wr_q[$];
    logic [AW-1:0] exp_rd_q[$];
    int            n_wr = 0, n_rd = 0, n_ss = 0, n_sl = 0, n_sd = 0;
    bit            sb_on = 1'b0;

    function automatic logic [DW-1:0] word(input int i);
        return {32'(i), 32'(i), 32'(i), 32'h0};
    endfunction

    function automatic logic [159:0] outs_vec();
        return {particle_wr_en, particle_addr, particle_wr_data, spread_start, solve_start,
                force_rd_en, force_addr, busy, step_done, err};
    endfunction

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic sel_val(input int sel);
        case (sel)
            0:       return spread_start;
            1:       return solve_start;
            default: return step_done;
        endcase
    endfunction

    task automatic wait_pulse(input int sel, input int budget, input string name);
        bit hit = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (sel_val(sel)) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!hit) begin
            checks++;
            failures++;
            $display("FAIL %s: got no pulse within %0d cycles, required one pulse", name, budget);
        end
    endtask

    task automatic start_cmd(input logic [1:0] s);
        @(negedge clk);
        start_sig = s;
        @(negedge clk);
        start_sig = 2'b00;
    endtask

    // Last word is not held so the caller can catch the spread_start that follows it.
    task automatic stream(input int first, input int last, input int pause_after,
                          input int pause_len, input int stray_at);
        wr_t e;
        int  g0;
        for (int i = first; i <= last; i++) begin
            @(negedge clk);
            user_data_available = 1'b1;
            user_buffer_data    = word(i);
            if (sb_on) begin
                e.addr = AW'(i);
                e.data = word(i);
                exp_wr_q.push_back(e);
            end
            if (i == stray_at) begin
                spread_done = 1'b1;
                solve_done  = 1'b1;
                start_sig   = 2'b10;
            end
            if (i != last) begin
                for (int j = 1; j < WC; j++) begin
                    @(negedge clk);
                    spread_done = 1'b0;
                    solve_done  = 1'b0;
                    start_sig   = 2'b00;
                end
            end
            if (i == pause_after) begin
                @(negedge clk);
                user_data_available = 1'b0;
                g0 = n_wr;
                repeat (pause_len - 1) @(negedge clk);
                chk("pause_no_write", n_wr - g0, 0);
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        user_data_available = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        vec_t vecs[4];
        int   b_wr, b_rd, b_ss, b_sl, b_sd, cw, cr, n_err;
        wr_t  e;

        rst = 1'b0; start_sig = 2'b00; user_buffer_data = '0;
        user_data_available = 1'b0; spread_done = 1'b0; solve_done = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (particle_wr_en) begin
                    n_wr++;
                    if (sb_on) begin
                        chk("wr_expected", exp_wr_q.size() != 0, 1);
                        if (exp_wr_q.size() != 0) begin
                            e = exp_wr_q.pop_front();
                            chk("wr_addr", particle_addr, e.addr);
                            chk("wr_data", particle_wr_data, e.data);
                        end
                    end
                end
                if (force_rd_en) begin
                    n_rd++;
                    if (sb_on) begin
                        chk("rd_expected", exp_rd_q.size() != 0, 1);
                        if (exp_rd_q.size() != 0) chk("rd_addr", force_addr, exp_rd_q.pop_front());
                    end
                end
                if (spread_start) n_ss++;
                if (solve_start)  n_sl++;
                if (step_done)    n_sd++;
            end
            begin
                #1_000_000;
                $display("FAIL global_timeout: got no finish by 1ms, required finish");
                $fatal(1, "global timeout");
            end
        join_none

        repeat (3) @(negedge clk);
        chk("reset_outputs", outs_vec(), 0);
        @(negedge clk);
        rst = 1'b1;

        // Start-code decode from IDLE: busy after acceptance and which strobe the first two samples drive.
        vecs[0] = '{2'b00, 1'b0, 0, 0};
        vecs[1] = '{2'b01, 1'b1, 2, 0};
        vecs[2] = '{2'b11, 1'b1, 2, 0};
        vecs[3] = '{2'b10, 1'b1, 0, 2};
        for (int v = 0; v < 4; v++) begin
            start_cmd(vecs[v].start);
            user_data_available = 1'b1;
            user_buffer_data    = word(7);
            chk($sformatf("tbl%0d_busy", v), busy, vecs[v].exp_busy);
            cw = 0;
            cr = 0;
            repeat (8) begin
                @(negedge clk);
                cw += int'(particle_wr_en);
                cr += int'(force_rd_en);
            end
            chk($sformatf("tbl%0d_wr", v), cw, vecs[v].exp_wr);
            chk($sformatf("tbl%0d_rd", v), cr, vecs[v].exp_rd);
            pulse_reset();
        end

        // Full step with a 37-cycle pause after word 500, stray done pulses and a stray start in LOAD.
        sb_on = 1'b1;
        b_wr = n_wr; b_rd = n_rd; b_ss = n_ss; b_sl = n_sl; b_sd = n_sd;
        start_cmd(2'b01);
        stream(0, NP - 1, 500, 37, 200);
        wait_pulse(0, 50, "spread_start");
        spread_done = 1'b1;
        solve_done  = 1'b1;
        @(negedge clk);
        spread_done = 1'b0;
        solve_done  = 1'b0;
        repeat (99) @(negedge clk);
        chk("solve_start_early", n_sl - b_sl, 0);
        chk("busy_in_spread", busy, 1);
        spread_done = 1'b1;
        @(negedge clk);
        spread_done = 1'b0;
        wait_pulse(1, 10, "solve_start");
        repeat (100) @(negedge clk);
        for (int i = 0; i < NP; i++) exp_rd_q.push_back(AW'(i));
        user_data_available = 1'b1;
        solve_done = 1'b1;
        @(negedge clk);
        solve_done = 1'b0;
        @(negedge clk);
        chk("first_read_cycle", force_rd_en, 1);
        wait_pulse(2, NP * WC + 50, "step_done");
        repeat (2) @(negedge clk);
        user_data_available = 1'b0;
        chk("full_writes", n_wr - b_wr, NP);
        chk("full_reads", n_rd - b_rd, NP);
        chk("full_spread_starts", n_ss - b_ss, 1);
        chk("full_solve_starts", n_sl - b_sl, 1);
        chk("full_step_dones", n_sd - b_sd, 1);
        chk("full_queues_empty", exp_wr_q.size() + exp_rd_q.size(), 0);
        chk("full_idle_busy", busy, 0);

        // Readback only.
        b_wr = n_wr; b_rd = n_rd; b_ss = n_ss; b_sd = n_sd;
        for (int i = 0; i < NP; i++) exp_rd_q.push_back(AW'(i));
        start_cmd(2'b10);
        user_data_available = 1'b1;
        wait_pulse(2, NP * WC + 50, "rb_step_done");
        repeat (2) @(negedge clk);
        user_data_available = 1'b0;
        chk("rb_writes", n_wr - b_wr, 0);
        chk("rb_spread_starts", n_ss - b_ss, 0);
        chk("rb_reads", n_rd - b_rd, NP);
        chk("rb_step_dones", n_sd - b_sd, 1);
        chk("rb_queue_empty", exp_rd_q.size(), 0);

        // Reset mid-LOAD after word 1000, then a fresh load must start at address 0.
        b_sd = n_sd;
        start_cmd(2'b01);
        stream(0, 1000, -1, 0, -1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        user_data_available = 1'b0;
        @(negedge clk);
        chk("midload_reset_outputs", outs_vec(), 0);
        chk("midload_queue_empty", exp_wr_q.size(), 0);
        rst = 1'b1;
        b_wr = n_wr;
        start_cmd(2'b01);
        stream(0, 19, -1, 0, -1);
        repeat (3) @(negedge clk);
        chk("restart_writes", n_wr - b_wr, 20);
        chk("restart_queue_empty", exp_wr_q.size(), 0);
        chk("midload_no_step_done", n_sd - b_sd, 0);
        pulse_reset();

        // Withheld solve_done: watchdog fault or indefinite wait depending on the build.
        start_cmd(2'b01);
        stream(0, NP - 1, -1, 0, -1);
        wait_pulse(0, 50, "wd_spread_start");
        repeat (10) @(negedge clk);
        spread_done = 1'b1;
        @(negedge clk);
        spread_done = 1'b0;
        wait_pulse(1, 10, "wd_solve_start");
        n_err = 0;
        for (int c = 1; c <= TMO + 200; c++) begin
            @(negedge clk);
            if (err && n_err == 0) n_err = c;
        end
`ifdef ELECTRO_WATCHDOG_EN
        chk("wd_err_cycle", n_err, TMO);
        chk("wd_err_level", err, 1);
        chk("wd_busy", busy, 0);
        start_cmd(2'b01);
        chk("wd_err_cleared", err, 0);
        chk("wd_restart_busy", busy, 1);
`else
        chk("nowd_err_never", n_err, 0);
        chk("nowd_still_busy", busy, 1);
`endif
        chk("wd_queue_empty", exp_wr_q.size(), 0);
        sb_on = 1'b0;
        pulse_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/electro_step_sequencer.md
# electro_step_sequencer

Phase sequencer for the long-range electrostatics engine: accepts one start command per MD step, paces particle words from the host user buffer into particle memory, triggers charge spreading and the grid solve, then paces force readback words out to the force buffer. Sits between the host streaming interface (`user_buffer_data` / `user_data_available`) and the spread, solve and interpolation sub-engines inside `Top_Electro`.

## Interface
- `NUM_PARTICLES`, 2048, particle words per step (load and readback)
- `ADDR_W`, 11, particle/force address width; `2**ADDR_W >= NUM_PARTICLES`
- `DATA_W`, 128, host word width
- `WORD_CYCLES`, 4, clock cycles each host word is held on the bus (>= 2)
- `TIMEOUT_CYCLES`, 65536, watchdog limit for SPREAD and SOLVE
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `start_sig`  in  2  01/11 = full step, 10 = readback only, 00 = none
- `user_buffer_data`  in  DATA_W  host particle word
- `user_data_available`  in  1  host word stream active (level)
- `spread_done`  in  1  single-cycle pulse from charge spreader
- `solve_done`  in  1  single-cycle pulse from grid solver
- `particle_wr_en`  out  1  particle memory write strobe
- `particle_addr`  out  ADDR_W  particle write address
- `particle_wr_data`  out  DATA_W  registered host word
- `spread_start`, `solve_start`  out  1  single-cycle start pulses
- `force_rd_en`  out  1  force readback strobe
- `force_addr`  out  ADDR_W  force read address
- `busy`  out  1  high in any state except IDLE and ERR
- `step_done`  out  1  single-cycle pulse at end of step
- `err`  out  1  watchdog fault, sticky until next accepted start

## Operation
- States: IDLE, LOAD, SPREAD, SOLVE, READ, DONE, ERR.
- IDLE/ERR: `start_sig` sampled; 01/11 -> LOAD, 10 -> READ; acceptance clears `err`, `particle_addr`, `force_addr`, pace counter. `start_sig` ignored in all other states.
- Pace counter: counts 0..WORD_CYCLES-1 while `user_data_available` high in LOAD/READ; held at 0 while low (pause, no word lost, resumes from 0). Sample point = count 0 on first available cycle, then every WORD_CYCLES cycles.
- LOAD: at each sample point, register `user_buffer_data`, pulse `particle_wr_en`, address = word index; address increments after write. After word NUM_PARTICLES-1 written -> SPREAD.
- SPREAD: `spread_start` pulsed on first cycle; `spread_done` honoured only from the following cycle -> SOLVE.
- SOLVE: same with `solve_start`/`solve_done` -> READ.
- READ: at each sample point pulse `force_rd_en` with `force_addr` = word index; after index NUM_PARTICLES-1 -> DONE.
- DONE: one cycle, `step_done` = 1 -> IDLE.
- Addresses never wrap within a step; no writes/reads beyond NUM_PARTICLES-1.

## Timing
- Reset (`rst` low): state IDLE immediately; all outputs 0 (`particle_wr_data` = 0); takes effect mid-operation with no completion pulses.
- Start accepted on edge N -> state LOAD/READ on N+1.
- Sample at edge S -> `particle_wr_en`, `particle_addr`, `particle_wr_data` valid for exactly one cycle after S; `force_rd_en`/`force_addr` likewise.
- Last LOAD write cycle -> `spread_start` high the next cycle.
- `solve_done` at edge D -> first READ cycle D+1.
- Full step with no pauses: LOAD = NUM_PARTICLES*WORD_CYCLES cycles.
- `spread_done`/`solve_done` outside their state: ignored.

## Configuration
- `ELECTRO_WATCHDOG_EN` defined: cycle counter cleared on entry to SPREAD/SOLVE; reaching TIMEOUT_CYCLES-1 without the done pulse -> ERR, `err` = 1, `busy` = 0. Done on the same cycle as timeout wins (normal transition).
- Not defined: no counter; SPREAD/SOLVE wait indefinitely; `err` tied 0, ERR unreachable.

## Test plan
- Full step: start 01, stream 2048 words (held 4 cycles, word i = {i,i,i,0}), done pulses after 100 cycles each, available again -> 2048 writes at addr 0..2047 data = word i, one each of `spread_start`/`solve_start`, 2048 `force_rd_en` addr 0..2047, one `step_done`.
- Pause: drop `user_data_available` for 37 cycles after word 500 -> no strobe during gap, word 501 written to addr 501, total writes exactly 2048.
- Readback only: start 10 -> no `particle_wr_en`/`spread_start`; 2048 force reads then `step_done`.
- Early/stray done: `spread_done` pulsed in LOAD and same cycle as `spread_start` -> ignored; state remains until later pulse.
- Reset mid-LOAD at word 1000 -> all outputs 0 next cycle, IDLE; new start 01 writes from addr 0.
- Watchdog (macro on, TIMEOUT_CYCLES=1000): withhold `solve_done` -> `err` = 1 after 1000 SOLVE cycles, `busy` = 0; start 01 clears `err`. Macro off: waits indefinitely, `err` stays 0.
